// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq
// Brief   : Handshaked ALU; single-cycle ops, iterative MUL/DIVU/REMU.
// Rev     : 1.0  initial release
// ============================================================================
module alu_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero
);

  localparam int c_shamt_w = $clog2(DATA_WIDTH);
  localparam int c_cnt_w   = $clog2(DATA_WIDTH);

  localparam logic [OPCODE_LENGTH-1:0] c_op_and  = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] c_op_or   = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] c_op_add  = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] c_op_sub  = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] c_op_sll  = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] c_op_srl  = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] c_op_sra  = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] c_op_slt  = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] c_op_eq   = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] c_op_xor  = OPCODE_LENGTH'(4'b1001);
  localparam logic [OPCODE_LENGTH-1:0] c_op_sltu = OPCODE_LENGTH'(4'b1010);
  localparam logic [OPCODE_LENGTH-1:0] c_op_mul  = OPCODE_LENGTH'(4'b1011);
  localparam logic [OPCODE_LENGTH-1:0] c_op_divu = OPCODE_LENGTH'(4'b1100);
  localparam logic [OPCODE_LENGTH-1:0] c_op_remu = OPCODE_LENGTH'(4'b1101);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       ready_en_q;
  logic [OPCODE_LENGTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0]      a_q, a_d;
  logic [DATA_WIDTH-1:0]      b_q, b_d;
  logic [DATA_WIDTH-1:0]      acc_q, acc_d;
  logic [c_cnt_w-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]      res_q, res_d;
  logic                       zero_q, zero_d;

  logic [c_shamt_w-1:0]       w_shamt;
  logic [DATA_WIDTH-1:0]      w_single;
  logic                       w_is_iter;
  logic                       w_accept;
  logic [DATA_WIDTH-1:0]      w_mul_acc;
  logic [DATA_WIDTH:0]        w_shifted;
  logic                       w_ge;
  logic [DATA_WIDTH-1:0]      w_rem;
  logic [DATA_WIDTH-1:0]      w_quo;
  logic [DATA_WIDTH-1:0]      w_iter_res;

  assign w_shamt   = SrcB[c_shamt_w-1:0];
  assign w_is_iter = (Operation == c_op_mul) || (Operation == c_op_divu) ||
                     (Operation == c_op_remu);

  always_comb begin
    w_single = '0;
    case (Operation)
      c_op_and:  w_single = SrcA & SrcB;
      c_op_or:   w_single = SrcA | SrcB;
      c_op_add:  w_single = SrcA + SrcB;
      c_op_sub:  w_single = SrcA - SrcB;
      c_op_sll:  w_single = SrcA << w_shamt;
      c_op_srl:  w_single = SrcA >> w_shamt;
      c_op_sra:  w_single = $signed(SrcA) >>> w_shamt;
      c_op_slt:  w_single = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      c_op_eq:   w_single = {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB};
      c_op_xor:  w_single = SrcA ^ SrcB;
      c_op_sltu: w_single = {{(DATA_WIDTH-1){1'b0}}, SrcA < SrcB};
      default:   w_single = '0;
    endcase
  end

  // Multiply: a_q is the shifting multiplicand, b_q the multiplier, acc_q the product.
  // Divide: a_q shifts the dividend out MSB-first and the quotient in LSB-first,
  // acc_q is the partial remainder; a zero divisor naturally yields all-ones / SrcA.
  assign w_mul_acc  = acc_q + (b_q[0] ? a_q : '0);
  assign w_shifted  = {acc_q, a_q[DATA_WIDTH-1]};
  assign w_ge       = w_shifted >= {1'b0, b_q};
  assign w_rem      = w_ge ? DATA_WIDTH'(w_shifted - {1'b0, b_q}) : w_shifted[DATA_WIDTH-1:0];
  assign w_quo      = {a_q[DATA_WIDTH-2:0], w_ge};
  assign w_iter_res = (op_q == c_op_mul)  ? w_mul_acc :
                      (op_q == c_op_divu) ? w_quo     : w_rem;

  assign w_accept  = in_valid && in_ready;
  assign ALUResult = res_q;
  assign Zero      = zero_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    zero_d    = zero_q;
    in_ready  = (state_q == IDLE) && ready_en_q;
    out_valid = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          if (w_is_iter) begin
            op_d    = Operation;
            a_d     = SrcA;
            b_d     = SrcB;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            res_d   = w_single;
            zero_d  = (w_single == '0);
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + c_cnt_w'(1);
        if (op_q == c_op_mul) begin
          acc_d = w_mul_acc;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end else begin
          acc_d = w_rem;
          a_d   = w_quo;
        end
        if (cnt_q == c_cnt_w'(DATA_WIDTH-1)) begin
          cnt_d   = '0;
          res_d   = w_iter_res;
          zero_d  = (w_iter_res == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ready_en_q keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      zero_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_seq
// Brief   : Directed and random self-checking bench for alu_seq.
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_seq;

  localparam int DW = 32;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] SrcA;
  logic [DW-1:0] SrcB;
  logic [3:0]    Operation;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] ALUResult;
  logic          Zero;

  int checks = 0;
  int errors = 0;

  alu_seq #(.DATA_WIDTH(DW), .OPCODE_LENGTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Operation (Operation),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the opcode table.
  function automatic logic [DW-1:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    longint unsigned sh;
    logic [DW-1:0]   ones;
    logic [DW-1:0]   r;
    ones = '1;
    sh   = longint'(b) % DW;
    r    = '0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a - b;
      4'd4:  r = a << sh;
      4'd5:  r = a >> sh;
      4'd6:  r = (a >> sh) | (a[DW-1] ? ~(ones >> sh) : '0);
      4'd7:  r = (longint'($signed(a)) < longint'($signed(b))) ? 1 : 0;
      4'd8:  r = (a == b) ? 1 : 0;
      4'd9:  r = a ^ b;
      4'd10: r = (longint'(a) < longint'(b)) ? 1 : 0;
      4'd11: r = DW'(longint'(a) * longint'(b));
      4'd12: r = (b == 0) ? ones : a / b;
      4'd13: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Issue one request, check latency/result/Zero against the model, optionally
  // stall in DONE for `hold` cycles while hammering in_valid with junk requests.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input int hold, input bit noise,
                        output logic [DW-1:0] res);
    int            n;
    int            lat;
    int            exp_lat;
    bit            rdy_busy;
    bit            unstable;
    logic [DW-1:0] exp;
    logic [DW-1:0] first;
    exp     = model(op, a, b);
    exp_lat = (op == 4'd11 || op == 4'd12 || op == 4'd13) ? DW : 0;
    SrcA = a; SrcB = b; Operation = op; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_accept_wait"}, (n < 50) ? 1 : 0, 1);
    @(posedge clk); #1;
    in_valid  = noise;
    SrcA      = $urandom;
    SrcB      = $urandom;
    Operation = 4'd2;
    lat = 0;
    rdy_busy = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_busy = 1'b1;
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_latency"}, DW'(lat), DW'(exp_lat));
    chk({tag, "_ready_busy"}, DW'(rdy_busy), 0);
    chk({tag, "_result"}, ALUResult, exp);
    chk({tag, "_zero"}, DW'(Zero), DW'(exp == '0));
    res      = ALUResult;
    first    = ALUResult;
    unstable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (ALUResult !== first || out_valid !== 1'b1 || in_ready !== 1'b0) unstable = 1'b1;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, DW'(unstable), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_released"}, {30'd0, out_valid, in_ready}, 2'b01);
    in_valid = 1'b0;
    if (noise) chk({tag, "_noise_kept"}, ALUResult, exp);
  endtask

  initial begin
    logic [DW-1:0] r;
    logic [3:0]    op;
    logic [DW-1:0] a, b;
    int            n;
    bit            stray;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    SrcA = '0; SrcB = '0; Operation = '0;
    #12;
    chk("rst_in_ready", DW'(in_ready), 0);
    chk("rst_out_valid", DW'(out_valid), 0);
    chk("rst_result", ALUResult, 0);
    chk("rst_zero", DW'(Zero), 1);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready_after_edge", DW'(in_ready), 1);

    run_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'h1, 0, 0, r);
    chk("add_ovf_lit", r, 32'h8000_0000);
    run_op("sub_zero", 4'd3, 32'd5, 32'd5, 0, 0, r);
    chk("sub_zero_lit", {r[31:1], Zero}, 32'h1);
    run_op("slt", 4'd7, 32'hFFFF_FFFF, 32'h1, 0, 0, r);
    chk("slt_lit", r, 32'd1);
    run_op("sltu", 4'd10, 32'hFFFF_FFFF, 32'h1, 0, 0, r);
    chk("sltu_lit", r, 32'd0);
    run_op("sra", 4'd6, 32'h8000_0000, 32'h21, 0, 0, r);
    chk("sra_lit", r, 32'hC000_0000);
    run_op("mul_wrap", 4'd11, 32'h1_0000, 32'h1_0000, 0, 0, r);
    chk("mul_wrap_lit", r, 32'd0);
    run_op("mul_hold", 4'd11, 32'd7, 32'd6, 10, 1, r);
    chk("mul_hold_lit", r, 32'd42);
    run_op("divu", 4'd12, 32'd100, 32'd7, 0, 0, r);
    chk("divu_lit", r, 32'd14);
    run_op("remu", 4'd13, 32'd100, 32'd7, 0, 0, r);
    chk("remu_lit", r, 32'd2);
    run_op("divu0", 4'd12, 32'd5, 32'd0, 0, 0, r);
    chk("divu0_lit", r, 32'hFFFF_FFFF);
    run_op("remu0", 4'd13, 32'd5, 32'd0, 3, 1, r);
    chk("remu0_lit", r, 32'd5);
    run_op("undef", 4'd15, 32'hDEAD_BEEF, 32'h1234, 0, 0, r);
    run_op("add_hold", 4'd2, 32'd10, 32'd20, 10, 1, r);

    // Abort a divide in flight with an asynchronous reset pulse.
    SrcA = 32'd1000; SrcB = 32'd3; Operation = 4'd12; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_out_valid", DW'(out_valid), 0);
    chk("abort_result", ALUResult, 0);
    chk("abort_zero", DW'(Zero), 1);
    chk("abort_in_ready", DW'(in_ready), 0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_after", DW'(in_ready), 1);
    stray = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) stray = 1'b1;
    end
    chk("abort_no_stray_valid", DW'(stray), 0);
    run_op("post_abort_add", 4'd2, 32'd2, 32'd3, 0, 0, r);
    chk("post_abort_add_lit", r, 32'd5);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_001F;
      if ($urandom_range(0, 7) == 0) b = '0;
      if (op == 4'd8 && $urandom_range(0, 1) == 1) b = a;
      run_op("rand", op, a, b, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
